ysyx_22040175_mem_arb: RTL and testbench

YSYX_22040175_MEM_ARB -- requirements
Module: ysyx_22040175_mem_arb

---
 rtl/ysyx_22040175_mem_arb.sv | 175 +++++++++++++++++
 tb/tb_ysyx_22040175_mem_arb.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040175_mem_arb.sv
// Two-master (IF/LSU) arbiter onto one shared memory port, one transaction in flight.
// Round-robin on ties, registered one-cycle responses, and a per-transaction timeout.
module ysyx_22040175_mem_arb #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_ready,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_err,
  input  logic                  lsu_valid,
  input  logic                  lsu_we,
  input  logic [ADDR_W-1:0]     lsu_addr,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wstrb,
  output logic                  lsu_ready,
  output logic                  lsu_rvalid,
  output logic [DATA_W-1:0]     lsu_rdata,
  output logic                  lsu_err,
  output logic                  mem_valid,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata
);
  localparam int SW = DATA_W / 8;
  localparam logic [16:0] TO_LIM = 17'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e              state_q, state_d;
  logic                last_q, last_d;    // 1: LSU was granted last
  logic                owner_q, owner_d;  // 1: LSU owns the transaction
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]       wstrb_q, wstrb_d;
  logic [16:0]         cnt_q, cnt_d;
  logic                if_rvalid_q, if_rvalid_d, if_err_q, if_err_d;
  logic                lsu_rvalid_q, lsu_rvalid_d, lsu_err_q, lsu_err_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d, lsu_rdata_q, lsu_rdata_d;

  logic grant_if, grant_lsu, timeout_hit, rsp_fire, rsp_err;

  assign grant_if    = if_valid && (!lsu_valid || last_q);
  assign grant_lsu   = lsu_valid && (!if_valid || !last_q);
  // Response register lands one cycle after the decision, so fire one count early.
  assign timeout_hit = (cnt_q + 17'd2) >= TO_LIM;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    cnt_d    = cnt_q;
    rsp_fire = 1'b0;
    rsp_err  = 1'b0;
    if_ready  = 1'b0;
    lsu_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_if && !rst) begin
          if_ready = 1'b1;
          owner_d  = 1'b0;
          last_d   = 1'b0;
          addr_d   = if_addr;
          we_d     = 1'b0;
          wdata_d  = '0;
          wstrb_d  = '0;
          cnt_d    = '0;
          state_d  = REQ;
        end else if (grant_lsu && !rst) begin
          lsu_ready = 1'b1;
          owner_d   = 1'b1;
          last_d    = 1'b1;
          addr_d    = lsu_addr;
          we_d      = lsu_we;
          wdata_d   = lsu_wdata;
          wstrb_d   = lsu_we ? lsu_wstrb : '0;
          cnt_d     = '0;
          state_d   = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 17'd1;
        if (mem_ready && mem_rvalid) begin
          rsp_fire = 1'b1;
          state_d  = IDLE;
        end else if (timeout_hit) begin
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
          state_d  = IDLE;
        end else if (mem_ready) begin
          state_d  = RESP;
        end
      end
      RESP: begin
        cnt_d = cnt_q + 17'd1;
        if (mem_rvalid) begin
          rsp_fire = 1'b1;
          state_d  = IDLE;
        end else if (timeout_hit) begin
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if_rvalid_d  = rsp_fire && !owner_q;
    lsu_rvalid_d = rsp_fire && owner_q;
    if_err_d     = rsp_fire && rsp_err && !owner_q;
    lsu_err_d    = rsp_fire && rsp_err && owner_q;
    if_rdata_d   = if_rvalid_d  ? (rsp_err ? '0 : mem_rdata) : if_rdata_q;
    lsu_rdata_d  = lsu_rvalid_d ? (rsp_err ? '0 : mem_rdata) : lsu_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      cnt_q        <= '0;
      if_rvalid_q  <= 1'b0;
      if_err_q     <= 1'b0;
      if_rdata_q   <= '0;
      lsu_rvalid_q <= 1'b0;
      lsu_err_q    <= 1'b0;
      lsu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      cnt_q        <= cnt_d;
      if_rvalid_q  <= if_rvalid_d;
      if_err_q     <= if_err_d;
      if_rdata_q   <= if_rdata_d;
      lsu_rvalid_q <= lsu_rvalid_d;
      lsu_err_q    <= lsu_err_d;
      lsu_rdata_q  <= lsu_rdata_d;
    end
  end

  assign mem_valid  = (state_q == REQ);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = wstrb_q;
  assign if_rvalid  = if_rvalid_q;
  assign if_err     = if_err_q;
  assign if_rdata   = if_rdata_q;
  assign lsu_rvalid = lsu_rvalid_q;
  assign lsu_err    = lsu_err_q;
  assign lsu_rdata  = lsu_rdata_q;
endmodule

// File: tb/tb_ysyx_22040175_mem_arb.sv
// Bench for the IF/LSU memory arbiter: vector table plus hand-written corner sequences,
// with a reactive memory model and a response scoreboard.
module tb_ysyx_22040175_mem_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        if_valid = 1'b0, lsu_valid = 1'b0, lsu_we = 1'b0;
  logic [31:0] if_addr = '0, lsu_addr = '0, lsu_wdata = '0;
  logic [3:0]  lsu_wstrb = '0;
  logic        if_ready, if_rvalid, if_err, lsu_ready, lsu_rvalid, lsu_err;
  logic [31:0] if_rdata, lsu_rdata;
  logic        mem_valid, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  ysyx_22040175_mem_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .lsu_valid(lsu_valid), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_ready(lsu_ready),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  // 64-bit data build
  logic        w_if_valid = 1'b0, w_lsu_valid = 1'b0, w_lsu_we = 1'b0;
  logic [31:0] w_if_addr = '0, w_lsu_addr = '0;
  logic [63:0] w_lsu_wdata = '0;
  logic [7:0]  w_lsu_wstrb = '0;
  logic        w_if_ready, w_if_rvalid, w_if_err, w_lsu_ready, w_lsu_rvalid, w_lsu_err;
  logic [63:0] w_if_rdata, w_lsu_rdata;
  logic        w_mem_valid, w_mem_we;
  logic [31:0] w_mem_addr;
  logic [63:0] w_mem_wdata;
  logic [7:0]  w_mem_wstrb;
  logic        w_mem_ready = 1'b0, w_mem_rvalid = 1'b0;
  logic [63:0] w_mem_rdata = '0;

  ysyx_22040175_mem_arb #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(255)) dut64 (
    .clk(clk), .rst(rst),
    .if_valid(w_if_valid), .if_addr(w_if_addr), .if_ready(w_if_ready),
    .if_rvalid(w_if_rvalid), .if_rdata(w_if_rdata), .if_err(w_if_err),
    .lsu_valid(w_lsu_valid), .lsu_we(w_lsu_we), .lsu_addr(w_lsu_addr),
    .lsu_wdata(w_lsu_wdata), .lsu_wstrb(w_lsu_wstrb), .lsu_ready(w_lsu_ready),
    .lsu_rvalid(w_lsu_rvalid), .lsu_rdata(w_lsu_rdata), .lsu_err(w_lsu_err),
    .mem_valid(w_mem_valid), .mem_we(w_mem_we), .mem_addr(w_mem_addr),
    .mem_wdata(w_mem_wdata), .mem_wstrb(w_mem_wstrb), .mem_ready(w_mem_ready),
    .mem_rvalid(w_mem_rvalid), .mem_rdata(w_mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0413 : ((a ^ 32'hA5A5_0F0F) + 32'h1);
  endfunction

  // Memory model: ready after ready_lat waiting cycles, response resp_lat cycles after ready.
  int          ready_lat = 0, resp_lat = 0, wcnt = 0, rcnt = 0;
  bit          mem_en = 1'b1, no_resp = 1'b0, pend = 1'b0;
  logic        man_ready = 1'b0, man_rvalid = 1'b0;
  logic [31:0] man_rdata = '0, paddr = '0;

  always @(negedge clk) begin
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    if (!mem_en) begin
      mem_ready  = man_ready;
      mem_rvalid = man_rvalid;
      mem_rdata  = man_rdata;
      pend = 1'b0;
      wcnt = 0;
    end else if (no_resp) begin
      pend = 1'b0;
      wcnt = 0;
    end else if (pend) begin
      if (rcnt >= resp_lat) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mdata(paddr);
        pend = 1'b0;
      end else rcnt++;
    end else if (mem_valid) begin
      if (wcnt >= ready_lat) begin
        mem_ready = 1'b1;
        wcnt = 0;
        if (resp_lat == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mdata(mem_addr);
        end else begin
          pend  = 1'b1;
          rcnt  = 1;
          paddr = mem_addr;
        end
      end else wcnt++;
    end
  end

  typedef struct packed { logic lsu; logic [31:0] data; logic err; } exp_t;
  exp_t sb[$];

  typedef struct {
    bit ifv; bit lsv; bit we;
    logic [31:0] ifa; logic [31:0] lsa; logic [31:0] wd; logic [3:0] ws;
    int rdy; int rsp; bit exp_lsu;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_rvalid || lsu_rvalid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: if_rvalid %0b lsu_rvalid %0b, expected no response", if_rvalid, lsu_rvalid);
        end else begin
          e = sb.pop_front();
          chk("rsp_owner", {if_rvalid, lsu_rvalid}, e.lsu ? 2'b01 : 2'b10);
          chk("rsp_data", e.lsu ? lsu_rdata : if_rdata, e.data);
          chk("rsp_err", e.lsu ? lsu_err : if_err, e.err);
        end
      end
      if (if_ready || lsu_ready) begin
        chk("one_grant", if_ready & lsu_ready, 1'b0);
        if (if_ready) sb.push_back('{1'b0, no_resp ? 32'h0 : mdata(if_addr), no_resp});
        else          sb.push_back('{1'b1, no_resp ? 32'h0 : mdata(lsu_addr), no_resp});
      end
    end
  endtask

  task automatic wait_drain(input string nm);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk); #1;
      done = (sb.size() == 0);
    end
    chk({nm, "_drain"}, done, 1'b1);
    if (!done) sb.delete();
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit got = 1'b0, who = 1'b0;
    @(posedge clk); #1;
    ready_lat = v.rdy; resp_lat = v.rsp;
    if_valid = v.ifv; if_addr = v.ifa;
    lsu_valid = v.lsv; lsu_addr = v.lsa; lsu_we = v.we; lsu_wdata = v.wd; lsu_wstrb = v.ws;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (if_ready || lsu_ready) begin
        got = 1'b1;
        who = lsu_ready;
      end
    end
    chk($sformatf("vec%0d_grant", idx), {got, who}, {1'b1, v.exp_lsu});
    @(posedge clk); #1;
    if_valid = 1'b0; lsu_valid = 1'b0;
    wait_drain($sformatf("vec%0d", idx));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1, 1, 0, 32'h8000_0004, 32'h8000_2000, 32'h0,         4'h0, 0, 0, 0};
    tbl[1] = '{1, 1, 0, 32'h8000_0008, 32'h8000_2004, 32'h0,         4'h0, 1, 2, 1};
    tbl[2] = '{1, 1, 1, 32'h8000_000C, 32'h8000_2008, 32'h1234_5678, 4'hF, 2, 1, 0};
    tbl[3] = '{1, 0, 0, 32'h8000_0010, 32'h0,         32'h0,         4'h0, 0, 3, 0};
    tbl[4] = '{0, 1, 1, 32'h0,         32'h8000_2010, 32'hCAFE_F00D, 4'h5, 3, 0, 1};
    tbl[5] = '{0, 1, 0, 32'h0,         32'h8000_2014, 32'h0,         4'h0, 1, 1, 1};
    tbl[6] = '{1, 1, 0, 32'h8000_0018, 32'h8000_2018, 32'h0,         4'h0, 0, 1, 0};

    fork monitor(); join_none

    // Reset: outputs quiet even with a request pending
    if_valid = 1'b1; if_addr = 32'h8000_0000;
    repeat (2) @(negedge clk);
    chk("rst_ready", {if_ready, lsu_ready}, 2'b00);
    chk("rst_rsp", {if_rvalid, if_err, lsu_rvalid, lsu_err}, 4'h0);
    chk("rst_mem", {mem_valid, mem_we, mem_wstrb, mem_addr}, 38'h0);
    chk("rst_rdata", {if_rdata, lsu_rdata}, 64'h0);
    @(posedge clk); #1;
    if_valid = 1'b0;
    rst = 1'b0;

    // Table: first three rounds are back-to-back ties (IF, LSU, IF)
    for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

    // Minimum-latency IF fetch
    ready_lat = 0; resp_lat = 0;
    @(posedge clk); #1;
    if_valid = 1'b1; if_addr = 32'h8000_0000;
    @(negedge clk);
    chk("lat_ready_c0", {if_ready, mem_valid}, 2'b10);
    @(posedge clk); #1;
    if_valid = 1'b0;
    @(negedge clk);
    chk("lat_mem_c1", {mem_valid, mem_we, mem_wstrb}, {1'b1, 1'b0, 4'h0});
    chk("lat_addr_c1", mem_addr, 32'h8000_0000);
    chk("lat_rvalid_c1", if_rvalid, 1'b0);
    @(negedge clk);
    chk("lat_rvalid_c2", {if_rvalid, mem_valid}, 2'b10);
    chk("lat_rdata_c2", if_rdata, 32'h0000_0413);
    wait_drain("lat");

    // Store with mem_ready held low for 4 cycles
    ready_lat = 4; resp_lat = 0;
    @(posedge clk); #1;
    lsu_valid = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h8000_1000;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'h3;
    @(negedge clk);
    chk("st_ready", lsu_ready, 1'b1);
    @(posedge clk); #1;
    lsu_valid = 1'b0; lsu_we = 1'b0; lsu_wdata = '0; lsu_wstrb = '0; lsu_addr = '0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("st_hold_c%0d", c), {mem_valid, mem_we, mem_wstrb, mem_addr},
          {1'b1, 1'b1, 4'h3, 32'h8000_1000});
      chk($sformatf("st_wdata_c%0d", c), mem_wdata, 32'hDEAD_BEEF);
    end
    @(negedge clk);
    chk("st_rsp", {lsu_rvalid, lsu_err, if_rvalid, mem_valid}, 4'b1000);
    wait_drain("st");

    // Timeout: memory silent, error response exactly 8 cycles after accept
    no_resp = 1'b1; ready_lat = 0;
    @(posedge clk); #1;
    if_valid = 1'b1; if_addr = 32'h8000_0040;
    @(negedge clk);
    chk("to_ready", if_ready, 1'b1);
    @(posedge clk); #1;
    if_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk($sformatf("to_wait_c%0d", c), {if_rvalid, mem_valid}, 2'b01);
    end
    @(negedge clk);
    chk("to_rsp_c8", {if_rvalid, if_err, mem_valid}, 3'b110);
    chk("to_rdata_c8", if_rdata, 32'h0);
    @(posedge clk); #1;
    no_resp = 1'b0; resp_lat = 0;
    if_valid = 1'b1; if_addr = 32'h8000_0044;
    @(negedge clk);
    chk("to_idle_regrant", if_ready, 1'b1);
    @(posedge clk); #1;
    if_valid = 1'b0;
    wait_drain("to");

    // Reset while waiting for the response; late mem_rvalid must be ignored
    mem_en = 1'b0; man_ready = 1'b0; man_rvalid = 1'b0;
    @(posedge clk); #1;
    if_valid = 1'b1; if_addr = 32'h8000_0080;
    @(negedge clk);
    chk("rr_ready", if_ready, 1'b1);
    @(posedge clk); #1;
    if_valid = 1'b0; man_ready = 1'b1;
    @(posedge clk); #1;
    man_ready = 1'b0;
    @(negedge clk);
    chk("rr_in_resp", {mem_valid, if_rvalid}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("rr_rst_out", {if_rvalid, lsu_rvalid, mem_valid, if_err}, 4'h0);
    chk("rr_rst_rdata", if_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    man_rvalid = 1'b1; man_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    man_rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rr_quiet_%0d", c), {if_rvalid, lsu_rvalid, mem_valid}, 3'b000);
    end
    mem_en = 1'b1;
    run_vec('{1, 0, 0, 32'h8000_0100, 32'h0, 32'h0, 4'h0, 0, 1, 0}, 7);

    // 64-bit build: load ignores wstrb, full-width data returned
    @(posedge clk); #1;
    w_lsu_valid = 1'b1; w_lsu_we = 1'b0; w_lsu_addr = 32'h8000_3000;
    w_lsu_wstrb = 8'hFF; w_lsu_wdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    chk("w64_ready", w_lsu_ready, 1'b1);
    @(posedge clk); #1;
    w_lsu_valid = 1'b0;
    w_mem_ready = 1'b1; w_mem_rvalid = 1'b1; w_mem_rdata = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    chk("w64_mem", {w_mem_valid, w_mem_we, w_mem_wstrb}, {1'b1, 1'b0, 8'h00});
    chk("w64_addr", w_mem_addr, 32'h8000_3000);
    @(posedge clk); #1;
    w_mem_ready = 1'b0; w_mem_rvalid = 1'b0; w_mem_rdata = '0;
    @(negedge clk);
    chk("w64_rsp", {w_lsu_rvalid, w_lsu_err, w_if_rvalid}, 3'b100);
    chk("w64_rdata", w_lsu_rdata, 64'h0123_4567_89AB_CDEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
